uart_cmd_decoder: RTL and testbench

Parametrised ASCII command decoder between the UART receiver (rdy/rdy_clr/dout handshake) and the motor PWM generators. It parses frames of the form `<channel letter><1..MAX_DIGITS decimal digits><terminator>`, where `#` means forward and `!` means reverse. On each valid frame it updates a per-channel saturated setpoint and direction. Malformed frames are rejected with an error pulse, and a channel letter received mid-frame restarts parsing.

---
 rtl/uart_cmd_pkg.sv | 17 +
 rtl/cmd_sat_accum.sv | 21 ++
 rtl/uart_cmd_decoder.sv | 194 +++++++++++++++++++
 tb/tb_uart_cmd_decoder.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: ASCII constants and FSM state type shared by the
// UART command decoder and its arithmetic sub-module.
package uart_cmd_pkg;

   localparam logic [7:0] ASC_0   = 8'd48;
   localparam logic [7:0] ASC_9   = 8'd57;
   localparam logic [7:0] ASC_FWD = 8'd35;
   localparam logic [7:0] ASC_REV = 8'd33;

   typedef enum logic [1:0] {
      IDLE,
      HDR_ACK,
      WAIT_DIG,
      DIG_ACK
   } state_t;

endpackage

// File: rtl/cmd_sat_accum.sv
// cmd_sat_accum: combinational acc*10+digit clamped to 2^DATA_W-1.
// Ports: acc (current value), digit (0..9), acc_nxt (clamped result).
module cmd_sat_accum #(
   parameter int DATA_W = 8
) (
   input  logic [DATA_W+3:0] acc,
   input  logic [3:0]        digit,
   output logic [DATA_W+3:0] acc_nxt
);

   localparam logic [DATA_W+3:0] CEIL = {4'b0000, {DATA_W{1'b1}}};

   logic [DATA_W+3:0] sum;

   // acc is always <= CEIL, so acc*10+9 fits in DATA_W+4 bits.
   always_comb begin
      sum     = acc * (DATA_W+4)'(10) + {{DATA_W{1'b0}}, digit};
      acc_nxt = (sum > CEIL) ? CEIL : sum;
   end

endmodule

// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: parses "<ch><digits><#|!>" frames from a UART and
// updates per-channel saturated setpoints and directions.
// Ports: CLOCK_50, RESET_N, rdy/dout/rdy_clr (UART), duty/dir/upd
// (per channel), err (reject pulse), busy (frame open).
// Optional inter-byte timeout: define UART_CMD_TIMEOUT_EN.
module uart_cmd_decoder
   import uart_cmd_pkg::*;
#(
   parameter int                  NUM_CH      = 2,
   parameter int                  DATA_W      = 8,
   parameter int                  MAX_DIGITS  = 3,
   parameter logic [NUM_CH*8-1:0] CH_IDS      = {8'd66, 8'd65},
   parameter int                  TIMEOUT_CYC = 5_000_000
) (
   input  logic                     CLOCK_50,
   input  logic                     RESET_N,
   input  logic                     rdy,
   input  logic [7:0]               dout,
   output logic                     rdy_clr,
   output logic [NUM_CH*DATA_W-1:0] duty,
   output logic [NUM_CH-1:0]        dir,
   output logic [NUM_CH-1:0]        upd,
   output logic                     err,
   output logic                     busy
);

   localparam int AW = DATA_W + 4;
   localparam int CW = $clog2(MAX_DIGITS + 1);
   localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   state_t                    state_q, state_d;
   logic [7:0]                rx_q, rx_d;
   logic [IW-1:0]             ch_q, ch_d;
   logic [AW-1:0]             acc_q, acc_d, acc_nxt;
   logic [CW-1:0]             cnt_q, cnt_d;
   logic [NUM_CH*DATA_W-1:0]  duty_q, duty_d;
   logic [NUM_CH-1:0]         dir_q, dir_d;
   logic [NUM_CH-1:0]         upd_q, upd_d;
   logic                      err_q, err_d;
   logic [NUM_CH-1:0]         match;
   logic                      hit;
   logic [IW-1:0]             hit_idx;
   logic                      is_dig, is_term;
   logic                      tmo_hit;

   genvar g;
   generate
      for (g = 0; g < NUM_CH; g++) begin : g_match
         assign match[g] = (rx_q == CH_IDS[8*g +: 8]);
      end
   endgenerate

   // Lowest matching channel wins.
   always_comb begin
      hit_idx = '0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         if (match[k]) hit_idx = IW'(k);
      end
   end

   assign hit     = |match;
   assign is_dig  = (rx_q >= ASC_0) && (rx_q <= ASC_9);
   assign is_term = (rx_q == ASC_FWD) || (rx_q == ASC_REV);

   // ASCII '0'..'9' carry their value in the low nibble.
   cmd_sat_accum #(.DATA_W(DATA_W)) u_acc (
      .acc     (acc_q),
      .digit   (rx_q[3:0]),
      .acc_nxt (acc_nxt)
   );

`ifdef UART_CMD_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   logic [TW-1:0] tmo_q;

   assign tmo_hit = (state_q == WAIT_DIG) &&
                    (tmo_q == TW'(TIMEOUT_CYC - 1));

   // Counts cycles spent in WAIT_DIG; any consumed byte leaves it.
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N)                           tmo_q <= '0;
      else if (state_q == WAIT_DIG && !tmo_hit) tmo_q <= tmo_q + TW'(1);
      else                                    tmo_q <= '0;
   end
`else
   logic unused_tmo;
   assign tmo_hit    = 1'b0;
   assign unused_tmo = (TIMEOUT_CYC != 0);
`endif

   always_comb begin
      state_d = state_q;
      rx_d    = rx_q;
      ch_d    = ch_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      duty_d  = duty_q;
      dir_d   = dir_q;
      upd_d   = '0;
      err_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (rdy) begin
               rx_d    = dout;
               state_d = HDR_ACK;
            end
         end
         HDR_ACK: begin
            state_d = IDLE;
            if (hit) begin
               ch_d    = hit_idx;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = WAIT_DIG;
            end
         end
         WAIT_DIG: begin
            if (tmo_hit) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else if (rdy) begin
               rx_d    = dout;
               state_d = DIG_ACK;
            end
         end
         DIG_ACK: begin
            state_d = IDLE;
            unique case (1'b1)
               is_dig: begin
                  if (cnt_q < CW'(MAX_DIGITS)) begin
                     acc_d   = acc_nxt;
                     cnt_d   = cnt_q + CW'(1);
                     state_d = WAIT_DIG;
                  end else begin
                     err_d = 1'b1;
                  end
               end
               is_term: begin
                  if (cnt_q != '0) begin
                     duty_d[int'(ch_q)*DATA_W +: DATA_W] = acc_q[DATA_W-1:0];
                     dir_d[ch_q] = (rx_q == ASC_FWD);
                     upd_d[ch_q] = 1'b1;
                  end else begin
                     err_d = 1'b1;
                  end
               end
               hit: begin
                  // A new header mid-frame rejects the old frame
                  // and opens a fresh one on the new channel.
                  err_d   = 1'b1;
                  ch_d    = hit_idx;
                  acc_d   = '0;
                  cnt_d   = '0;
                  state_d = WAIT_DIG;
               end
               default: err_d = 1'b1;
            endcase
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= IDLE;
         rx_q    <= '0;
         ch_q    <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         duty_q  <= '0;
         dir_q   <= '0;
         upd_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rx_q    <= rx_d;
         ch_q    <= ch_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         duty_q  <= duty_d;
         dir_q   <= dir_d;
         upd_q   <= upd_d;
         err_q   <= err_d;
      end
   end

   assign rdy_clr = (state_q == HDR_ACK) || (state_q == DIG_ACK);
   assign busy    = (state_q == WAIT_DIG) || (state_q == DIG_ACK);
   assign duty    = duty_q;
   assign dir     = dir_q;
   assign upd     = upd_q;
   assign err     = err_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// tb_uart_cmd_decoder: directed frames with a UART handshake model and
// an event scoreboard for upd/err pulses.
module tb_uart_cmd_decoder;

   logic        CLOCK_50;
   logic        RESET_N;
   logic        rdy;
   logic [7:0]  dout;
   logic        rdy_clr;
   logic [15:0] duty;
   logic [1:0]  dir;
   logic [1:0]  upd;
   logic        err;
   logic        busy;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct packed {
      logic [1:0]  upd;
      logic        err;
      logic [15:0] duty;
      logic [1:0]  dir;
   } ev_t;

   ev_t sbq[$];

   uart_cmd_decoder #(
      .NUM_CH      (2),
      .DATA_W      (8),
      .MAX_DIGITS  (3),
      .CH_IDS      ({8'd66, 8'd65}),
      .TIMEOUT_CYC (100)
   ) dut (
      .CLOCK_50 (CLOCK_50),
      .RESET_N  (RESET_N),
      .rdy      (rdy),
      .dout     (dout),
      .rdy_clr  (rdy_clr),
      .duty     (duty),
      .dir      (dir),
      .upd      (upd),
      .err      (err),
      .busy     (busy)
   );

   initial CLOCK_50 = 1'b0;
   always #10 CLOCK_50 = ~CLOCK_50;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [1:0] u, input logic e,
                       input logic [15:0] d, input logic [1:0] r);
      ev_t ev;
      ev = {u, e, d, r};
      sbq.push_back(ev);
   endtask

   // Any upd/err pulse must match the next queued expectation.
   always @(negedge CLOCK_50) begin
      if (RESET_N && (upd != 2'b00 || err)) begin
         ev_t ev;
         check("excl", {31'b0, (err && |upd) || (upd == 2'b11)}, 0);
         if (sbq.size() == 0) begin
            check("unexpected_evt", {29'b0, upd, err}, 0);
         end else begin
            ev = sbq.pop_front();
            check("upd", {30'b0, upd}, {30'b0, ev.upd});
            check("err", {31'b0, err}, {31'b0, ev.err});
            check("duty", {16'b0, duty}, {16'b0, ev.duty});
            check("dir", {30'b0, dir}, {30'b0, ev.dir});
         end
      end
   end

   // UART model: present byte, drop rdy once rdy_clr is seen.
   task automatic send_byte(input logic [7:0] b);
      dout = b;
      rdy  = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge CLOCK_50);
         if (rdy_clr) break;
      end
      check("ack", {31'b0, rdy_clr}, 1);
      rdy = 1'b0;
      @(negedge CLOCK_50);
      check("clr_1cyc", {31'b0, rdy_clr}, 0);
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i]);
   endtask

   initial begin
      int cnt;
      RESET_N = 1'b0;
      rdy     = 1'b0;
      dout    = 8'h00;
      repeat (3) @(negedge CLOCK_50);
      check("rst_duty", {16'b0, duty}, 0);
      check("rst_dir", {30'b0, dir}, 0);
      check("rst_pulses", {28'b0, upd, err, rdy_clr}, 0);
      check("rst_busy", {31'b0, busy}, 0);
      RESET_N = 1'b1;
      @(negedge CLOCK_50);

      // A128# -> forward 128 on channel 0
      send_str("A");
      check("busy_open", {31'b0, busy}, 1);
      send_str("128");
      push(2'b01, 1'b0, 16'h0080, 2'b01);
      send_byte("#");
      check("upd_pulse", {30'b0, upd}, 2'b01);
      @(negedge CLOCK_50);
      check("upd_low", {30'b0, upd}, 0);
      check("busy_closed", {31'b0, busy}, 0);

      // B300! -> saturated to 255, reverse
      send_str("B300");
      push(2'b10, 1'b0, 16'hFF80, 2'b01);
      send_byte("!");

      // A12B7# -> restart on B
      send_str("A12");
      push(2'b00, 1'b1, 16'hFF80, 2'b01);
      send_byte("B");
      check("busy_restart", {31'b0, busy}, 1);
      send_str("7");
      push(2'b10, 1'b0, 16'h0780, 2'b11);
      send_byte("#");

      // A# -> empty digits
      send_str("A");
      push(2'b00, 1'b1, 16'h0780, 2'b11);
      send_byte("#");

      // A1234# -> too many digits, '#' then dropped in IDLE
      send_str("A123");
      push(2'b00, 1'b1, 16'h0780, 2'b11);
      send_byte("4");
      check("busy_after_err", {31'b0, busy}, 0);
      send_byte("#");

      // xA5# -> junk header dropped
      send_str("xA5");
      push(2'b01, 1'b0, 16'h0705, 2'b11);
      send_byte("#");

      // nothing consumed while rdy is low
      rdy  = 1'b0;
      dout = "A";
      cnt  = 0;
      repeat (10) begin
         @(negedge CLOCK_50);
         if (rdy_clr) cnt++;
      end
      check("no_consume", cnt, 0);
      check("idle_busy", {31'b0, busy}, 0);

      // reset during the ACK of '9'
      send_str("A");
      dout = "9";
      rdy  = 1'b1;
      @(negedge CLOCK_50);
      check("pre_rst_ack", {31'b0, rdy_clr}, 1);
      #2 RESET_N = 1'b0;
      #1;
      check("arst_rdy_clr", {31'b0, rdy_clr}, 0);
      check("arst_duty", {16'b0, duty}, 0);
      check("arst_dir", {30'b0, dir}, 0);
      check("arst_busy", {31'b0, busy}, 0);
      rdy = 1'b0;
      repeat (3) @(negedge CLOCK_50);
      RESET_N = 1'b1;
      @(negedge CLOCK_50);
      send_str("5#");
      repeat (3) @(negedge CLOCK_50);
      check("post_rst_duty", {16'b0, duty}, 0);
      check("post_rst_busy", {31'b0, busy}, 0);

      // boundaries: reverse small, zero value, saturation
      send_str("A25");
      push(2'b01, 1'b0, 16'h0019, 2'b00);
      send_byte("!");
      send_str("B0");
      push(2'b10, 1'b0, 16'h0019, 2'b10);
      send_byte("#");
      send_str("B999");
      push(2'b10, 1'b0, 16'hFF19, 2'b10);
      send_byte("#");

`ifdef UART_CMD_TIMEOUT_EN
      push(2'b00, 1'b1, 16'hFF19, 2'b10);
      send_str("A4");
      repeat (120) @(negedge CLOCK_50);
      check("tmo_closed", {31'b0, busy}, 0);
      check("tmo_duty", {16'b0, duty}, 32'h0000FF19);
`else
      send_str("A4");
      repeat (120) @(negedge CLOCK_50);
      check("no_tmo_open", {31'b0, busy}, 1);
      push(2'b01, 1'b0, 16'hFF04, 2'b11);
      send_byte("#");
`endif

      repeat (5) @(negedge CLOCK_50);
      check("sb_empty", sbq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
